mux_sel_skid: RTL and testbench

- Parametrised N-input, WIDTH-bit registered multiplexer with a valid/ready handshake and a 2-entry skid buffer.
- Successor to the combinational 4:1 datapath selectors. Used between register-file/immediate/PC sources and the ALU operand latch in the multicycle datapath.
- in_ready is driven straight from a register, so the path from downstream ready to upstream ready is broken.

---
 rtl/mux_pkg.sv | 37 +++
 rtl/mux_sel_entry.sv | 28 ++
 rtl/mux_sel_skid.sv | 139 +++++++++++++
 tb/tb_mux_sel_skid.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the mux_sel_skid selector: occupancy state encoding
// and the word-pick helper used to index the flat input bus.
package mux_pkg;

    // Occupancy encoding: how many entries the block currently holds.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Upper bounds for the helper's bus; callers zero-extend into this shape.
    localparam int MUX_MAX_IN = 16;
    localparam int MUX_MAX_W  = 64;

    // Returns {err, word}. An index at or beyond n_in yields err=1 and an
    // all-zero word, so the datapath never sees an undriven value.
    function automatic logic [MUX_MAX_W:0] mux_pick(
        input logic [MUX_MAX_IN*MUX_MAX_W-1:0] bus,
        input logic [7:0]                      idx,
        input int                              n_in,
        input int                              width
    );
        logic [MUX_MAX_W:0]               r;
        logic [MUX_MAX_IN*MUX_MAX_W-1:0]  sh;
        r  = '0;
        sh = '0;
        if (int'(idx) >= n_in) begin
            r[MUX_MAX_W] = 1'b1;
        end else begin
            sh = bus >> (int'(idx) * width);
            for (int b = 0; b < MUX_MAX_W; b++) begin
                if (b < width) r[b] = sh[b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_sel_entry.sv
// One held entry {err, sel, data}: load-enabled register with synchronous clear.
module mux_sel_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d, q_q;

    // Next value: clear wins over load, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clr)     q_d = '0;
        else if (ld) q_d = d;
    end

    // Storage.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/mux_sel_skid.sv
// Registered N:1 selector with valid/ready handshake and a 2-entry skid
// buffer (output slot + skid slot). in_ready comes straight from a flop so
// downstream ready never reaches upstream ready combinationally.
// Optional MUX_SEL_STICKY_EN adds sel_ld and a sticky select register.
module mux_sel_skid
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        sel,
`ifdef MUX_SEL_STICKY_EN
    input  logic                    sel_ld,
`endif
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    localparam int ENT_W = WIDTH + SEL_W + 1;

    logic [1:0]                        state_d, state_q;
    logic                              in_ready_d, in_ready_q;
    logic                              out_valid_d, out_valid_q;
    logic                              accept, emit;
    logic                              out_ld, skid_ld;
    logic [ENT_W-1:0]                  entry_new, out_din, out_q, skid_q;
    logic [SEL_W-1:0]                  sel_eff;
    logic [MUX_MAX_IN*MUX_MAX_W-1:0]   bus_ext;
    logic [MUX_MAX_W:0]                pick;

    assign accept = in_valid && in_ready_q;
    assign emit   = out_valid_q && out_ready;

`ifdef MUX_SEL_STICKY_EN
    logic [SEL_W-1:0] sticky_d, sticky_q;

    // sel_ld=1 both uses and remembers sel; sel_ld=0 replays the stored index.
    always_comb begin
        sel_eff  = sel_ld ? sel : sticky_q;
        sticky_d = (accept && sel_ld) ? sel : sticky_q;
    end

    // Sticky select storage.
    always_ff @(posedge clk) begin
        if (rst) sticky_q <= '0;
        else     sticky_q <= sticky_d;
    end
`else
    assign sel_eff = sel;
`endif

    // Widen the input bus to the helper's fixed shape and build the new entry.
    always_comb begin
        bus_ext                   = '0;
        bus_ext[NUM_IN*WIDTH-1:0] = data_in;
        pick                      = mux_pick(bus_ext, 8'(sel_eff), NUM_IN, WIDTH);
        entry_new                 = {pick[MUX_MAX_W], sel_eff, pick[WIDTH-1:0]};
    end

    // Occupancy next-state and slot load enables; skid always drains into the
    // output slot first, which keeps strict FIFO order.
    always_comb begin
        state_d = state_q;
        out_ld  = 1'b0;
        skid_ld = 1'b0;
        out_din = entry_new;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_ld  = 1'b1;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    out_ld = 1'b1;
                end else if (accept) begin
                    skid_ld = 1'b1;
                    state_d = ST_TWO;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (emit) begin
                    out_ld  = 1'b1;
                    out_din = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Occupancy and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    mux_sel_entry #(.W(ENT_W)) u_out (
        .clk (clk),
        .clr (rst),
        .ld  (out_ld),
        .d   (out_din),
        .q   (out_q)
    );

    mux_sel_entry #(.W(ENT_W)) u_skid (
        .clk (clk),
        .clr (rst),
        .ld  (skid_ld),
        .d   (entry_new),
        .q   (skid_q)
    );

    assign {sel_err, out_sel, out_data} = out_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_sel_skid.sv
// Bench for mux_sel_skid: two instances (NUM_IN=4 and NUM_IN=3) share the
// handshake, select and low input words; a queue model predicts both.
module tb_mux_sel_skid;

    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      sel;
    logic            sel_ld;
    logic [4*W-1:0]  din;
    logic            in_valid, out_ready;

    logic            rdy_a, vld_a, err_a;
    logic [W-1:0]    dat_a;
    logic [1:0]      osel_a;
    logic            rdy_b, vld_b, err_b;
    logic [W-1:0]    dat_b;
    logic [1:0]      osel_b;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { logic [W-1:0] d; logic [1:0] s; logic e; } ent_t;
    ent_t       qa[$];
    ent_t       qb[$];
    logic [1:0] sticky_m;

    always #5 clk = ~clk;

    mux_sel_skid #(.WIDTH(W), .NUM_IN(4)) dut_a (
        .clk(clk), .rst(rst), .sel(sel),
`ifdef MUX_SEL_STICKY_EN
        .sel_ld(sel_ld),
`endif
        .data_in(din), .in_valid(in_valid), .in_ready(rdy_a),
        .out_data(dat_a), .out_sel(osel_a), .out_valid(vld_a),
        .out_ready(out_ready), .sel_err(err_a)
    );

    mux_sel_skid #(.WIDTH(W), .NUM_IN(3)) dut_b (
        .clk(clk), .rst(rst), .sel(sel),
`ifdef MUX_SEL_STICKY_EN
        .sel_ld(sel_ld),
`endif
        .data_in(din[3*W-1:0]), .in_valid(in_valid), .in_ready(rdy_b),
        .out_data(dat_b), .out_sel(osel_b), .out_valid(vld_b),
        .out_ready(out_ready), .sel_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference pick: word k of the bus, or zero with err when k is out of range.
    function automatic ent_t ref_pick(input logic [1:0] s, input int n);
        ent_t r;
        r.s = s;
        r.e = (int'(s) >= n);
        r.d = r.e ? '0 : din[int'(s)*W +: W];
        return r;
    endfunction

    task automatic drive(input logic v, input logic [1:0] s, input logic r, input logic ld);
        in_valid  = v;
        sel       = s;
        out_ready = r;
        sel_ld    = ld;
    endtask

    // Check outputs mid-cycle, then advance the model across one rising edge.
    task automatic step();
        logic       acc, emt;
        logic [1:0] s_eff;
        @(negedge clk);
        chk("a_in_ready",  {31'd0, rdy_a}, {31'd0, qa.size() < 2});
        chk("a_out_valid", {31'd0, vld_a}, {31'd0, qa.size() > 0});
        if (qa.size() > 0) begin
            chk("a_out_data", {16'd0, dat_a},  {16'd0, qa[0].d});
            chk("a_out_sel",  {30'd0, osel_a}, {30'd0, qa[0].s});
            chk("a_sel_err",  {31'd0, err_a},  {31'd0, qa[0].e});
        end
        chk("b_in_ready",  {31'd0, rdy_b}, {31'd0, qb.size() < 2});
        chk("b_out_valid", {31'd0, vld_b}, {31'd0, qb.size() > 0});
        if (qb.size() > 0) begin
            chk("b_out_data", {16'd0, dat_b},  {16'd0, qb[0].d});
            chk("b_out_sel",  {30'd0, osel_b}, {30'd0, qb[0].s});
            chk("b_sel_err",  {31'd0, err_b},  {31'd0, qb[0].e});
        end
`ifdef MUX_SEL_STICKY_EN
        s_eff = sel_ld ? sel : sticky_m;
`else
        s_eff = sel;
`endif
        acc = in_valid && (qa.size() < 2);
        emt = out_ready && (qa.size() > 0);
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
            sticky_m = 2'd0;
        end else begin
            if (emt) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (acc) begin
                qa.push_back(ref_pick(s_eff, 4));
                qb.push_back(ref_pick(s_eff, 3));
`ifdef MUX_SEL_STICKY_EN
                if (sel_ld) sticky_m = sel;
`endif
            end
        end
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vld"},  {31'd0, vld_a}, 32'd0);
        chk({tag, "_rdy"},  {31'd0, rdy_a}, 32'd1);
        chk({tag, "_data"}, {16'd0, dat_a}, 32'd0);
        chk({tag, "_sel"},  {30'd0, osel_a}, 32'd0);
        chk({tag, "_err"},  {31'd0, err_a}, 32'd0);
        chk({tag, "_b_vld"}, {31'd0, vld_b}, 32'd0);
    endtask

    initial begin
        sticky_m = 2'd0;
        din      = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        rst      = 1'b1;
        drive(1'b1, 2'd2, 1'b1, 1'b1);

        // Reset held two cycles with in_valid asserted.
        @(posedge clk); #1;
        chk_reset_vals("rst1");
        @(posedge clk); #1;
        chk_reset_vals("rst2");
        rst = 1'b0;

        // Single transfer sel=2.
        drive(1'b1, 2'd2, 1'b1, 1'b1);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b1);
        chk("single_data", {16'd0, dat_a}, 32'h0000CCCC);
        chk("single_vld",  {31'd0, vld_a}, 32'd1);
        step();

        // Backpressure: two accepts fill both slots, third is refused.
        drive(1'b1, 2'd0, 1'b0, 1'b1); step();
        drive(1'b1, 2'd3, 1'b0, 1'b1); step();
        chk("bp_full_rdy", {31'd0, rdy_a}, 32'd0);
        drive(1'b1, 2'd1, 1'b0, 1'b1); step();
        drive(1'b0, 2'd0, 1'b1, 1'b1);
        chk("bp_first", {16'd0, dat_a}, 32'h0000AAAA);
        step();
        chk("bp_second", {16'd0, dat_a}, 32'h0000DDDD);
        step(); step();

        // Streaming: 8 back-to-back accepts.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i % 4), 1'b1, 1'b1);
            step();
        end
        drive(1'b0, 2'd0, 1'b1, 1'b1); step(); step();

        // Out-of-range select on the 3-input instance, then back in range.
        drive(1'b1, 2'd3, 1'b1, 1'b1); step();
        chk("oor_err_b",  {31'd0, err_b}, 32'd1);
        chk("oor_data_b", {16'd0, dat_b}, 32'd0);
        drive(1'b1, 2'd1, 1'b1, 1'b1); step();
        chk("oor_clear_b", {31'd0, err_b}, 32'd0);
        drive(1'b0, 2'd0, 1'b1, 1'b1); step();

        // Reset while holding two entries; the skid entry must never appear.
        drive(1'b1, 2'd1, 1'b0, 1'b1); step();
        drive(1'b1, 2'd2, 1'b0, 1'b1); step();
        rst = 1'b1;
        drive(1'b0, 2'd0, 1'b1, 1'b1); step();
        rst = 1'b0;
        chk_reset_vals("midrst");
        step(); step();

`ifdef MUX_SEL_STICKY_EN
        // Sticky select: second accept ignores sel=3 and reuses index 1.
        drive(1'b1, 2'd1, 1'b1, 1'b1); step();
        chk("sticky_first", {16'd0, dat_a}, 32'h0000BBBB);
        drive(1'b1, 2'd3, 1'b1, 1'b0); step();
        chk("sticky_second", {16'd0, dat_a}, 32'h0000BBBB);
        drive(1'b0, 2'd0, 1'b1, 1'b1); step();
`endif

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            din = {$urandom, $urandom};
            rst = ($urandom_range(0, 63) == 0);
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom));
            step();
        end
        rst = 1'b0;
        drive(1'b0, 2'd0, 1'b1, 1'b1);
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
